// File: rtl/regfile_banked.sv
// regfile_banked: banked PDP-11 register file with per-mode SP, shared PC and an inc/dec update port.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the a/b/inc_old read paths.
module regfile_banked #(
    parameter int               WIDTH    = 16,
    parameter int               NBANKS   = 2,
    parameter int               BANKW    = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [1:0]       prev_mode,
    input  logic             use_prev,
    input  logic [BANKW-1:0] bank,
    input  logic [2:0]       sela,
    input  logic [2:0]       selb,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             we,
    input  logic [2:0]       selw,
    input  logic [WIDTH-1:0] w,
    input  logic             inc_en,
    input  logic [2:0]       inc_sel,
    input  logic             inc_dec,
    input  logic             inc_byte,
    output logic [WIDTH-1:0] inc_old
);
    // Flat storage: R0-R5 of every bank, then SP[0..3] by mode code, then PC.
    localparam int SP_BASE = 6 * NBANKS;
    localparam int PC_IDX  = SP_BASE + 4;
    localparam int NREG    = PC_IDX + 1;
    localparam int IW      = $clog2(NREG);

    logic [WIDTH-1:0] regs [NREG];
    logic [IW-1:0]    idx_a, idx_b, idx_w, idx_i;
    logic [1:0]       mode_aw;
    logic [WIDTH-1:0] step, inc_cur, inc_new;
    logic             w_hit;

    function automatic logic [IW-1:0] phys(input logic [2:0] sel, input logic [BANKW-1:0] bk,
                                           input logic [1:0] md);
        int bi;
        bi = (int'(bk) < NBANKS) ? int'(bk) : 0;
        if (sel == 3'd7)
            phys = IW'(PC_IDX);
        else if (sel == 3'd6)
            phys = IW'(SP_BASE + int'(md));
        else
            phys = IW'(bi * 6 + int'(sel));
    endfunction

    // Only ports A and W honour use_prev (MFPI/MTPI); B and the inc port follow mode.
    assign mode_aw = use_prev ? prev_mode : mode;
    assign idx_a   = phys(sela, bank, mode_aw);
    assign idx_b   = phys(selb, bank, mode);
    assign idx_w   = phys(selw, bank, mode_aw);
    assign idx_i   = phys(inc_sel, bank, mode);

    assign inc_cur = regs[idx_i];
    assign step    = (inc_byte && inc_sel < 3'd6) ? WIDTH'(1) : WIDTH'(2);
    assign inc_new = inc_dec ? inc_cur - step : inc_cur + step;
    assign w_hit   = we && (idx_w == idx_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
        end else begin
            if (inc_en && !w_hit)
                regs[idx_i] <= inc_new;
            if (we)
                regs[idx_w] <= w;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so outputs show the cleared storage.
    function automatic logic [WIDTH-1:0] fwd(input logic [IW-1:0] idx);
        if (reset && we && idx == idx_w)
            fwd = w;
        else if (reset && inc_en && idx == idx_i)
            fwd = inc_new;
        else
            fwd = regs[idx];
    endfunction

    assign a       = fwd(idx_a);
    assign b       = fwd(idx_b);
    assign inc_old = fwd(idx_i);
`else
    assign a       = regs[idx_a];
    assign b       = regs[idx_b];
    assign inc_old = inc_cur;
`endif

endmodule
